// File: rtl/fpu_round_pkg.sv
// Shared widths and request/response records for the FPU rounding-path
// normalize shifter and its arbiter.
package fpu_round_pkg;

   localparam int FR_W      = 57;
   localparam int SH_W      = 13;
   localparam int FN_W      = 128;
   localparam int TAG_W     = 4;
   localparam int NREQ_DEF  = 2;
   localparam int SRC_W_DEF = $clog2(NREQ_DEF);

   typedef struct packed {
      logic [FR_W-1:0]  fr;
      logic [SH_W-1:0]  sh;
      logic [TAG_W-1:0] tag;
   } norm_req_t;

   typedef struct packed {
      logic [FN_W-1:0]      fn;
      logic [SRC_W_DEF-1:0] src;
      logic [TAG_W-1:0]     tag;
   } norm_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past ptr (the last winner) and
// returns a one-hot grant plus its encoded index.
module rr_arbiter #(
   parameter  int N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_vld
);

   always_comb begin
      int idx;
      idx     = 0;
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!gnt_vld && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = IW'(idx);
            gnt_vld  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/signormshift.sv
// Combinational normalize shifter: fr sits in the top FR_W bits of the result,
// sh is signed (positive = shift right, negative = shift left); |sh| >= FN_W gives 0.
module signormshift
   import fpu_round_pkg::*;
(
   input  logic [FR_W-1:0] fr,
   input  logic [SH_W-1:0] sh,
   output logic [FN_W-1:0] fn
);

   localparam int PAD = FN_W - FR_W;

   logic [FN_W-1:0] base;
   logic [SH_W-1:0] mag;

   always_comb begin
      base = {fr, {PAD{1'b0}}};
      mag  = '0;
      fn   = '0;
      if (!sh[SH_W-1]) begin
         if (sh < SH_W'(FN_W)) fn = base >> sh;
      end else begin
         mag = -sh;
         if (mag < SH_W'(FN_W)) fn = base << mag;
      end
   end

endmodule

// File: rtl/norm_shift_arbiter.sv
// Shares one signormshift between NREQ requesters; the winner's result is
// captured in a single output register with its source index and tag.
module norm_shift_arbiter
   import fpu_round_pkg::*;
#(
   parameter  int NREQ  = NREQ_DEF,
   localparam int SRC_W = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*FR_W-1:0]  req_fr,
   input  logic [NREQ*SH_W-1:0]  req_sh,
   input  logic [NREQ*TAG_W-1:0] req_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [FN_W-1:0]       out_fn,
   output logic [SRC_W-1:0]      out_src,
   output logic [TAG_W-1:0]      out_tag
);

   logic             out_valid_q, out_valid_d;
   logic [FN_W-1:0]  out_fn_q, out_fn_d;
   logic [SRC_W-1:0] out_src_q, out_src_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;
   logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

   logic [NREQ-1:0]  gnt;
   logic [SRC_W-1:0] gnt_idx;
   logic             gnt_vld;
   logic             can_accept;
   logic             accept;
   norm_req_t        sel_req;
   logic [FN_W-1:0]  sel_fn;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   always_comb begin
      sel_req.fr  = req_fr[int'(gnt_idx)*FR_W +: FR_W];
      sel_req.sh  = req_sh[int'(gnt_idx)*SH_W +: SH_W];
      sel_req.tag = req_tag[int'(gnt_idx)*TAG_W +: TAG_W];
   end

   signormshift u_shift (
      .fr (sel_req.fr),
      .sh (sel_req.sh),
      .fn (sel_fn)
   );

   // flush blocks the accept so the pointer cannot advance in a flush cycle
   assign can_accept = !out_valid_q || out_ready;
   assign req_ready  = gnt & {NREQ{can_accept && !flush}};
   assign accept     = gnt_vld && can_accept && !flush;

   always_comb begin
      out_valid_d = out_valid_q;
      out_fn_d    = out_fn_q;
      out_src_d   = out_src_q;
      out_tag_d   = out_tag_q;
      rr_ptr_d    = rr_ptr_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         out_fn_d    = sel_fn;
         out_src_d   = gnt_idx;
         out_tag_d   = sel_req.tag;
         rr_ptr_d    = gnt_idx;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_fn_q    <= '0;
         out_src_q   <= '0;
         out_tag_q   <= '0;
         rr_ptr_q    <= SRC_W'(NREQ - 1);
      end else begin
         out_valid_q <= out_valid_d;
         out_fn_q    <= out_fn_d;
         out_src_q   <= out_src_d;
         out_tag_q   <= out_tag_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_fn    = out_fn_q;
   assign out_src   = out_src_q;
   assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_norm_shift_arbiter.sv
// Directed and randomized checks of the shared normalize-shift arbiter.
module tb_norm_shift_arbiter;
   import fpu_round_pkg::*;

   localparam int NR = 2;
   localparam logic [FR_W-1:0] C1_FR = 57'h123456789ABCDEF;
   localparam logic [SH_W-1:0] C1_SH = 13'b0101010101010;
   localparam logic [FR_W-1:0] C2_FR = 57'h0BCDEF123456789;
   localparam logic [SH_W-1:0] C2_SH = 13'b1110001110001;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 flush = 1'b0;
   logic [NR-1:0]        req_valid = '0;
   logic [NR-1:0]        req_ready;
   logic [NR*FR_W-1:0]   req_fr = '0;
   logic [NR*SH_W-1:0]   req_sh = '0;
   logic [NR*TAG_W-1:0]  req_tag = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [FN_W-1:0]      out_fn;
   logic [0:0]           out_src;
   logic [TAG_W-1:0]     out_tag;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   norm_shift_arbiter #(.NREQ(NR)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_fr    (req_fr),
      .req_sh    (req_sh),
      .req_tag   (req_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_fn    (out_fn),
      .out_src   (out_src),
      .out_tag   (out_tag)
   );

   // Reference: result bit j takes bit (j + signed shift) of {fr, zeros}.
   function automatic logic [FN_W-1:0] model_fn(input logic [FR_W-1:0] fr, input logic [SH_W-1:0] sh);
      int s, p;
      logic [FN_W-1:0] r;
      s = sh[SH_W-1] ? int'(sh) - (1 << SH_W) : int'(sh);
      r = '0;
      for (int j = 0; j < FN_W; j++) begin
         p = j + s;
         if (p >= FN_W - FR_W && p < FN_W) r[j] = fr[p - (FN_W - FR_W)];
      end
      return r;
   endfunction

   task automatic set_req(input int i, input logic [FR_W-1:0] fr, input logic [SH_W-1:0] sh,
                          input logic [TAG_W-1:0] tag);
      req_fr[i*FR_W +: FR_W]    = fr;
      req_sh[i*SH_W +: SH_W]    = sh;
      req_tag[i*TAG_W +: TAG_W] = tag;
   endtask

   // Requester contract: a pending request stays valid and stable until accepted.
   logic [NR-1:0]    c_pend = '0;
   logic [FR_W-1:0]  c_fr  [NR];
   logic [SH_W-1:0]  c_sh  [NR];
   logic [TAG_W-1:0] c_tag [NR];
   always @(negedge clk) begin
      if (!rst_n) c_pend = '0;
      else begin
         for (int i = 0; i < NR; i++) begin
            if (c_pend[i] && (!req_valid[i] || req_fr[i*FR_W +: FR_W] !== c_fr[i] ||
                req_sh[i*SH_W +: SH_W] !== c_sh[i] || req_tag[i*TAG_W +: TAG_W] !== c_tag[i])) begin
               n_fail++;
               $display("FAIL req_contract[%0d]: request changed or dropped before accept at %0t", i, $time);
            end
            c_pend[i] = req_valid[i] && !req_ready[i];
            c_fr[i]   = req_fr[i*FR_W +: FR_W];
            c_sh[i]   = req_sh[i*SH_W +: SH_W];
            c_tag[i]  = req_tag[i*TAG_W +: TAG_W];
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_tests++; if (out_fn !== '0) begin n_fail++; $display("FAIL reset_out_fn: got %h want 0", out_fn); end
      n_tests++; if (out_src !== 1'b0) begin n_fail++; $display("FAIL reset_out_src: got %0d want 0", out_src); end
      n_tests++; if (out_tag !== '0) begin n_fail++; $display("FAIL reset_out_tag: got %0d want 0", out_tag); end
      n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      logic [FN_W-1:0] exp_fn;
      exp_fn = model_fn(C1_FR, C1_SH);
      set_req(0, C1_FR, C1_SH, 4'd3); req_valid = 2'b01; out_ready = 1'b1;
      @(negedge clk);
      n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b want 01", req_ready); end
      @(posedge clk); #1; req_valid = '0;
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
      n_tests++; if (out_src !== 1'b0) begin n_fail++; $display("FAIL single_src: got %0d want 0", out_src); end
      n_tests++; if (out_tag !== 4'd3) begin n_fail++; $display("FAIL single_tag: got %0d want 3", out_tag); end
      n_tests++; if (out_fn !== exp_fn) begin n_fail++; $display("FAIL single_fn: got %h want %h", out_fn, exp_fn); end
      @(posedge clk); #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain_valid: got %b want 0", out_valid); end
      n_tests++; if (out_fn !== exp_fn) begin n_fail++; $display("FAIL single_hold_fn: got %h want %h", out_fn, exp_fn); end
   endtask

   task automatic test_shift_vectors();
      logic [SH_W-1:0] shv [12] = '{13'd0, 13'd1, 13'd5, 13'd71, 13'd100, 13'd127, 13'd128,
                                    13'h1FFF, 13'h1FF9, 13'h1FC8, 13'h1FC7, 13'h1000};
      logic [FR_W-1:0] fr;
      logic [FN_W-1:0] exp_fn;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         fr = C1_FR + FR_W'(i) * 57'h1_0000_1111;
         exp_fn = model_fn(fr, shv[i]);
         set_req(0, fr, shv[i], TAG_W'(i)); req_valid = 2'b01;
         @(posedge clk); #1; req_valid = '0;
         n_tests++;
         if (out_valid !== 1'b1 || out_fn !== exp_fn || out_tag !== TAG_W'(i)) begin
            n_fail++;
            $display("FAIL shift_vec[%0d] sh=%h: got v=%b fn=%h tag=%0d want v=1 fn=%h tag=%0d",
                     i, shv[i], out_valid, out_fn, out_tag, exp_fn, i);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_contention();
      logic [FN_W-1:0] exp0, exp1;
      logic [NR-1:0]   exp_rdy;
      int g;
      @(negedge clk); rst_n = 1'b0; #1; rst_n = 1'b1;
      @(posedge clk); #1;
      exp0 = model_fn(C2_FR, C2_SH);
      exp1 = model_fn(C1_FR, C1_SH);
      set_req(0, C2_FR, C2_SH, 4'd5); set_req(1, C1_FR, C1_SH, 4'd3);
      req_valid = 2'b11; out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         g = k % 2;
         exp_rdy = NR'(1) << g;
         @(negedge clk);
         n_tests++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, exp_rdy); end
         @(posedge clk); #1;
         n_tests++;
         if (out_valid !== 1'b1 || out_src !== 1'(g) || out_tag !== (g == 1 ? 4'd3 : 4'd5) ||
             out_fn !== (g == 1 ? exp1 : exp0)) begin
            n_fail++;
            $display("FAIL rr_out[%0d]: got v=%b src=%0d tag=%0d want v=1 src=%0d", k, out_valid, out_src, out_tag, g);
         end
         if (k == 4) req_valid[0] = 1'b0;
      end
      req_valid = '0;
      @(posedge clk); #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_backpressure();
      logic [FN_W-1:0] exp0, exp1;
      exp0 = model_fn(C1_FR, 13'd9);
      exp1 = model_fn(C2_FR, 13'h1FF0);
      set_req(0, C1_FR, 13'd9, 4'd7); req_valid = 2'b01; out_ready = 1'b1;
      @(posedge clk); #1;
      set_req(1, C2_FR, 13'h1FF0, 4'd9); req_valid = 2'b10; out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 00", k, req_ready); end
         @(posedge clk); #1;
         n_tests++;
         if (out_valid !== 1'b1 || out_fn !== exp0 || out_tag !== 4'd7) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got v=%b tag=%0d fn=%h want v=1 tag=7 fn=%h", k, out_valid, out_tag, out_fn, exp0);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_release_ready: got %b want 10", req_ready); end
      @(posedge clk); #1; req_valid = '0;
      n_tests++;
      if (out_valid !== 1'b1 || out_src !== 1'b1 || out_tag !== 4'd9 || out_fn !== exp1) begin
         n_fail++;
         $display("FAIL bp_next: got v=%b src=%0d tag=%0d fn=%h want v=1 src=1 tag=9 fn=%h", out_valid, out_src, out_tag, out_fn, exp1);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_flush();
      set_req(0, C2_FR, 13'd3, 4'd2); req_valid = 2'b01; out_ready = 1'b1;
      @(posedge clk); #1;
      n_tests++; if (out_valid !== 1'b1 || out_tag !== 4'd2) begin n_fail++; $display("FAIL flush_pre: got v=%b tag=%0d want v=1 tag=2", out_valid, out_tag); end
      set_req(0, C1_FR, 13'd20, 4'd6); set_req(1, C2_FR, 13'd40, 4'd4);
      req_valid = 2'b11; flush = 1'b1;
      @(negedge clk);
      n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL flush_ready: got %b want 00", req_ready); end
      @(posedge clk); #1; flush = 1'b0;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
      @(negedge clk);
      n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL flush_ptr_kept: got %b want 10", req_ready); end
      @(posedge clk); #1; req_valid[1] = 1'b0;
      n_tests++;
      if (out_valid !== 1'b1 || out_src !== 1'b1 || out_tag !== 4'd4 || out_fn !== model_fn(C2_FR, 13'd40)) begin
         n_fail++; $display("FAIL flush_after_r1: got v=%b src=%0d tag=%0d want v=1 src=1 tag=4", out_valid, out_src, out_tag);
      end
      @(negedge clk);
      n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL flush_r0_ready: got %b want 01", req_ready); end
      @(posedge clk); #1; req_valid = '0;
      n_tests++;
      if (out_valid !== 1'b1 || out_src !== 1'b0 || out_tag !== 4'd6 || out_fn !== model_fn(C1_FR, 13'd20)) begin
         n_fail++; $display("FAIL flush_after_r0: got v=%b src=%0d tag=%0d want v=1 src=0 tag=6", out_valid, out_src, out_tag);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset();
      set_req(0, C1_FR, 13'd1, 4'd8); req_valid = 2'b01; out_ready = 1'b1;
      @(posedge clk); #1; req_valid = '0; out_ready = 1'b0;
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got %b want 1", out_valid); end
      #2; rst_n = 1'b0; #1;
      n_tests++;
      if (out_valid !== 1'b0 || out_fn !== '0 || out_tag !== '0 || out_src !== 1'b0) begin
         n_fail++; $display("FAIL arst_clear: got v=%b src=%0d tag=%0d fn=%h want all 0", out_valid, out_src, out_tag, out_fn);
      end
      @(posedge clk); @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      set_req(0, C2_FR, 13'd2, 4'd1); set_req(1, C1_FR, 13'd4, 4'd2);
      req_valid = 2'b11; out_ready = 1'b1;
      @(negedge clk);
      n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL arst_first_grant: got %b want 01", req_ready); end
      @(posedge clk); #1; req_valid[0] = 1'b0;
      n_tests++; if (out_src !== 1'b0 || out_tag !== 4'd1) begin n_fail++; $display("FAIL arst_out0: got src=%0d tag=%0d want src=0 tag=1", out_src, out_tag); end
      @(negedge clk);
      n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL arst_second_grant: got %b want 10", req_ready); end
      @(posedge clk); #1; req_valid = '0;
      n_tests++; if (out_src !== 1'b1 || out_tag !== 4'd2) begin n_fail++; $display("FAIL arst_out1: got src=%0d tag=%0d want src=1 tag=2", out_src, out_tag); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [FN_W-1:0]  qfn  [NR][$];
      logic [TAG_W-1:0] qtag [NR][$];
      int               wait_cnt [NR];
      logic [NR-1:0]    acc;
      logic [FN_W-1:0]  efn;
      logic [TAG_W-1:0] etag;
      int               s;
      for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
      for (int c = 0; c < 10010; c++) begin
         if (c < 10000) begin
            for (int i = 0; i < NR; i++) begin
               if (!req_valid[i] && $urandom_range(2) == 0) begin
                  set_req(i, FR_W'({$urandom, $urandom}), SH_W'(int'($urandom_range(300)) - 150), TAG_W'($urandom));
                  req_valid[i] = 1'b1;
               end
            end
            out_ready = ($urandom_range(3) != 0);
         end else begin
            out_ready = 1'b1;
         end
         @(negedge clk);
         if (out_valid && out_ready) begin
            s = int'(out_src);
            n_tests++;
            if (qfn[s].size() == 0) begin
               n_fail++; $display("FAIL rand_unexpected: result from src %0d with nothing outstanding at %0t", s, $time);
            end else begin
               efn = qfn[s].pop_front(); etag = qtag[s].pop_front();
               if (out_fn !== efn || out_tag !== etag) begin
                  n_fail++; $display("FAIL rand_data src %0d: got fn=%h tag=%0d want fn=%h tag=%0d", s, out_fn, out_tag, efn, etag);
               end
            end
         end
         acc = req_valid & req_ready;
         n_tests++; if (!$onehot0(acc)) begin n_fail++; $display("FAIL rand_onehot: got accept %b want at most one bit", acc); end
         for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
               qfn[i].push_back(model_fn(req_fr[i*FR_W +: FR_W], req_sh[i*SH_W +: SH_W]));
               qtag[i].push_back(req_tag[i*TAG_W +: TAG_W]);
               n_tests++;
               if (wait_cnt[i] > NR - 1) begin n_fail++; $display("FAIL rand_fairness src %0d: waited %0d accepts want <= %0d", i, wait_cnt[i], NR - 1); end
               wait_cnt[i] = 0;
            end else if (req_valid[i] && acc != '0) begin
               wait_cnt[i]++;
            end
         end
         @(posedge clk); #1;
         for (int i = 0; i < NR; i++) if (acc[i]) req_valid[i] = 1'b0;
      end
      for (int i = 0; i < NR; i++) begin
         n_tests++;
         if (qfn[i].size() != 0 || req_valid[i]) begin
            n_fail++; $display("FAIL rand_lost src %0d: got %0d results outstanding want 0", i, qfn[i].size());
         end
      end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_end_valid: got %b want 0", out_valid); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_shift_vectors();
      test_contention();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/norm_shift_arbiter.md
Name: norm_shift_arbiter

Overview:
Shares one signormshift instance (57-bit significand fr, 13-bit shift sh, 128-bit normalized result fn) between NREQ requesters, for example the adder and multiplier rounding paths. A round-robin arbiter picks one request per cycle and drives the shared shifter. The shifter result is captured in a single output register, together with its source ID and tag. Every requester port and the output port use a valid/ready handshake.

Parameters:
FR_W, 57, significand width fed to signormshift
SH_W, 13, shift-amount width
FN_W, 128, normalized result width
TAG_W, 4, opaque requester tag carried with the result
NREQ, 2, number of requesters (≥2)
SRC_W, $clog2(NREQ), source-ID width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous flush of the output register
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept (one-hot or zero)
req_fr  in  NREQ*FR_W  packed significands; requester i at [i*FR_W +: FR_W]
req_sh  in  NREQ*SH_W  packed shift amounts
req_tag  in  NREQ*TAG_W  packed tags
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_fn  out  FN_W  normalized result
out_src  out  SRC_W  index of the requester that produced out_fn
out_tag  out  TAG_W  tag of that request

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_fn=0, out_src=0, out_tag=0, rr_ptr=NREQ-1 (requester 0 wins first). req_ready is combinational and therefore 0 while out_valid=0 and no req_valid.
- can_accept = !out_valid | out_ready (pipeline-ready).
- Grant: round-robin search starting at (rr_ptr+1) mod NREQ; the first i with req_valid[i] wins.
- req_ready[grant] = can_accept & !flush; all other bits are 0. req_ready never depends on out_valid of other ports beyond can_accept.
- On accept (req_valid[g] & req_ready[g]):
  - the muxed fr/sh of g drive signormshift;
  - the next edge loads out_fn=fn, out_src=g, out_tag=req_tag[g], out_valid=1, rr_ptr=g.
- Latency is exactly 1 cycle from accept to out_valid. Throughput is 1 per cycle when out_ready is held at 1.
- Output held: out_valid=1 & out_ready=0 → out_fn/out_src/out_tag stable and no req_ready asserted.
- Output consumed with no new accept → out_valid=0 next cycle; data fields keep their last value.
- Simultaneous consume and accept → the register is overwritten with the new result and out_valid stays 1 (no bubble).
- Contention: with requesters 0 and 1 both valid every cycle and out_ready=1, grants alternate 0,1,0,1…
- rr_ptr updates only on an actual accept, never on an idle cycle.
- flush=1: out_valid←0 next edge and req_ready forced to 0 in that cycle (no accept, rr_ptr unchanged). flush takes priority over out_ready.
- Requester contract (asserted in the bench): once req_valid[i]=1, req_fr/sh/tag[i] stay stable and req_valid stays high until accepted.
- Reset asserted mid-transfer: outputs clear immediately (async); the in-flight result is lost; rr_ptr returns to NREQ-1.
- signormshift is purely combinational; the only state is the output register and rr_ptr.

Decomposition:
- Package fpu_round_pkg holds:
  - FR_W, SH_W, FN_W, TAG_W defaults;
  - typedef norm_req_t {fr, sh, tag};
  - typedef norm_rsp_t {fn, src, tag}.
- One sub-module: rr_arbiter (NREQ-wide request vector, ptr in, one-hot grant plus encoded index out), reused for later shared FPU resources.
- signormshift is instantiated unchanged.

Test Plan:
1. Reset, then req_valid=01, fr=57'h123456789ABCDEF, sh=13'b0101010101010, tag=3, out_ready=1 → req_ready=01 that cycle; next cycle out_valid=1, out_src=0, out_tag=3, out_fn equals the signormshift model for those inputs.
2. Both valid continuously (r0: fr=57'hABCDEF123456789, sh=13'b1110001110001; r1: the case-1 values), out_ready=1, 6 cycles → out_src sequence 0,1,0,1,0,1 with no bubbles.
3. out_ready=0 for 3 cycles after the first result → out_valid held at 1, out_fn/out_tag constant, req_ready=00 throughout; out_ready=1 → pending request accepted the same cycle, new result on the following cycle.
4. out_valid=1, flush=1 with r1 valid → next cycle out_valid=0, r1 not accepted, rr_ptr unchanged; r1 accepted the cycle after flush drops.
5. rst_n pulled low asynchronously between edges while out_valid=1 → out_valid=0 immediately; after release, with both valid, requester 0 is granted first.
6. Random valid/ready, 10k cycles, scoreboard per requester → every accepted request appears exactly once, in per-source order, with the correct fn/tag, and no requester waits more than NREQ accepts.
